// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter (with alu_types_pkg and alu)
//  Description : Two-requester round-robin front end sharing one registered ALU.
//  Revision    : 1.0 - initial release
// ============================================================================

package alu_types_pkg;
    typedef logic [4:0] alu_control_t;

    localparam alu_control_t ALU_ADD  = 5'd0;
    localparam alu_control_t ALU_SUB  = 5'd1;
    localparam alu_control_t ALU_AND  = 5'd2;
    localparam alu_control_t ALU_OR   = 5'd3;
    localparam alu_control_t ALU_XOR  = 5'd4;
    localparam alu_control_t ALU_SLL  = 5'd5;
    localparam alu_control_t ALU_SRL  = 5'd6;
    localparam alu_control_t ALU_SRA  = 5'd7;
    localparam alu_control_t ALU_SLT  = 5'd8;
    localparam alu_control_t ALU_SLTU = 5'd9;
    localparam alu_control_t ALU_BEQ  = 5'd10;
    localparam alu_control_t ALU_BNE  = 5'd11;
    localparam alu_control_t ALU_BLT  = 5'd12;
    localparam alu_control_t ALU_BGE  = 5'd13;
    localparam alu_control_t ALU_BLTU = 5'd14;
    localparam alu_control_t ALU_BGEU = 5'd15;
endpackage

module alu
    import alu_types_pkg::*;
(
    input  alu_control_t ctrl_i,
    input  logic [31:0]  in1_i,
    input  logic [31:0]  in2_i,
    output logic [31:0]  result_o
);
    logic [4:0] shamt;
    logic       lt_s;
    logic       lt_u;
    logic       eq;

    assign shamt = in2_i[4:0];
    assign lt_s  = $signed(in1_i) < $signed(in2_i);
    assign lt_u  = in1_i < in2_i;
    assign eq    = in1_i == in2_i;

    always_comb begin
        result_o = 32'd0;
        case (ctrl_i)
            ALU_ADD:  result_o = in1_i + in2_i;
            ALU_SUB:  result_o = in1_i - in2_i;
            ALU_AND:  result_o = in1_i & in2_i;
            ALU_OR:   result_o = in1_i | in2_i;
            ALU_XOR:  result_o = in1_i ^ in2_i;
            ALU_SLL:  result_o = in1_i << shamt;
            ALU_SRL:  result_o = in1_i >> shamt;
            ALU_SRA:  result_o = $unsigned($signed(in1_i) >>> shamt);
            ALU_SLT:  result_o = {31'd0, lt_s};
            ALU_SLTU: result_o = {31'd0, lt_u};
            ALU_BEQ:  result_o = {31'd0, eq};
            ALU_BNE:  result_o = {31'd0, ~eq};
            ALU_BLT:  result_o = {31'd0, lt_s};
            ALU_BGE:  result_o = {31'd0, ~lt_s};
            ALU_BLTU: result_o = {31'd0, lt_u};
            ALU_BGEU: result_o = {31'd0, ~lt_u};
            default:  result_o = 32'd0;
        endcase
    end
endmodule

module alu_arbiter
    import alu_types_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid_0,
    input  logic         req_valid_1,
    output logic         req_ready_0,
    output logic         req_ready_1,
    input  alu_control_t req_ctrl_0,
    input  alu_control_t req_ctrl_1,
    input  logic [31:0]  req_in1_0,
    input  logic [31:0]  req_in1_1,
    input  logic [31:0]  req_in2_0,
    input  logic [31:0]  req_in2_1,
    output logic         rsp_valid_0,
    output logic         rsp_valid_1,
    input  logic         rsp_ready_0,
    input  logic         rsp_ready_1,
    output logic [31:0]  rsp_result,
    output logic         busy
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]   state_q,      state_d;
    logic         owner_q,      owner_d;
    logic         last_grant_q, last_grant_d;
    alu_control_t ctrl_q,       ctrl_d;
    logic [31:0]  in1_q,        in1_d;
    logic [31:0]  in2_q,        in2_d;
    logic [31:0]  result_q,     result_d;

    logic         in_idle;
    logic         in_resp;
    logic         grant_sel;
    logic         accept;
    logic         rsp_hs;
    logic [31:0]  alu_result;

    alu u_alu (
        .ctrl_i   (ctrl_q),
        .in1_i    (in1_q),
        .in2_i    (in2_q),
        .result_o (alu_result)
    );

    assign in_idle = (state_q == ST_IDLE);
    assign in_resp = (state_q == ST_RESP);

    // Contention goes to whoever did not win last; a lone requester always wins.
    assign grant_sel = (req_valid_0 && req_valid_1) ? ~last_grant_q : req_valid_1;

    // rst_n gating keeps ready low during reset even though IDLE is the reset state.
    assign req_ready_0 = rst_n && in_idle && req_valid_0 && !grant_sel;
    assign req_ready_1 = rst_n && in_idle && req_valid_1 &&  grant_sel;
    assign accept      = req_ready_0 || req_ready_1;

    assign rsp_valid_0 = in_resp && !owner_q;
    assign rsp_valid_1 = in_resp &&  owner_q;
    assign rsp_result  = in_resp ? result_q : 32'd0;
    assign busy        = !in_idle;

    assign rsp_hs = owner_q ? rsp_ready_1 : rsp_ready_0;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        ctrl_d       = ctrl_q;
        in1_d        = in1_q;
        in2_d        = in2_q;
        result_d     = result_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    owner_d      = grant_sel;
                    last_grant_d = grant_sel;
                    ctrl_d       = grant_sel ? req_ctrl_1 : req_ctrl_0;
                    in1_d        = grant_sel ? req_in1_1  : req_in1_0;
                    in2_d        = grant_sel ? req_in2_1  : req_in2_0;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d = alu_result;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            ctrl_q       <= '0;
            in1_q        <= 32'd0;
            in2_q        <= 32'd0;
            result_q     <= 32'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            ctrl_q       <= ctrl_d;
            in1_q        <= in1_d;
            in2_q        <= in2_d;
            result_q     <= result_d;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Directed self-checking bench for alu_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_alu_arbiter;
    import alu_types_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         req_valid_0, req_valid_1;
    logic         req_ready_0, req_ready_1;
    alu_control_t req_ctrl_0,  req_ctrl_1;
    logic [31:0]  req_in1_0,   req_in1_1;
    logic [31:0]  req_in2_0,   req_in2_1;
    logic         rsp_valid_0, rsp_valid_1;
    logic         rsp_ready_0, rsp_ready_1;
    logic [31:0]  rsp_result;
    logic         busy;

    int n_checks;
    int n_errors;
    logic exp_g;

    alu_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_0 (req_valid_0),
        .req_valid_1 (req_valid_1),
        .req_ready_0 (req_ready_0),
        .req_ready_1 (req_ready_1),
        .req_ctrl_0  (req_ctrl_0),
        .req_ctrl_1  (req_ctrl_1),
        .req_in1_0   (req_in1_0),
        .req_in1_1   (req_in1_1),
        .req_in2_0   (req_in2_0),
        .req_in2_1   (req_in2_1),
        .rsp_valid_0 (rsp_valid_0),
        .rsp_valid_1 (rsp_valid_1),
        .rsp_ready_0 (rsp_ready_0),
        .rsp_ready_1 (rsp_ready_1),
        .rsp_result  (rsp_result),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-requester transaction starting in an IDLE cycle, 1 time unit after the edge.
    task automatic do_op(input string tag, input logic side, input alu_control_t ctrl,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        rsp_ready_0 = 1'b1;
        rsp_ready_1 = 1'b1;
        if (side) begin
            req_valid_1 = 1'b1; req_ctrl_1 = ctrl; req_in1_1 = a; req_in2_1 = b;
        end else begin
            req_valid_0 = 1'b1; req_ctrl_0 = ctrl; req_in1_0 = a; req_in2_0 = b;
        end
        #1;
        check_eq({tag, "_rdy"}, 32'(side ? req_ready_1 : req_ready_0), 32'd1);
        tick();
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
        tick();
        check_eq({tag, "_vld"}, 32'(side ? rsp_valid_1 : rsp_valid_0), 32'd1);
        check_eq({tag, "_res"}, rsp_result, exp);
        tick();
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        req_valid_0 = 1'b1;
        req_valid_1 = 1'b0;
        req_ctrl_0  = ALU_ADD;
        req_ctrl_1  = ALU_ADD;
        req_in1_0   = 32'd0;
        req_in1_1   = 32'd0;
        req_in2_0   = 32'd0;
        req_in2_1   = 32'd0;
        rsp_ready_0 = 1'b0;
        rsp_ready_1 = 1'b0;

        // Reset state
        #3;
        check_eq("rst_rdy0", 32'(req_ready_0), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_vld0", 32'(rsp_valid_0), 32'd0);
        check_eq("rst_vld1", 32'(rsp_valid_1), 32'd0);
        check_eq("rst_res",  rsp_result, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n       = 1'b1;
        req_valid_0 = 1'b0;
        tick();

        // Requester 0 alone: ADD 5+7
        req_ctrl_0 = ALU_ADD; req_in1_0 = 32'd5; req_in2_0 = 32'd7;
        req_valid_0 = 1'b1; rsp_ready_0 = 1'b1;
        #1;
        check_eq("a_rdy0", 32'(req_ready_0), 32'd1);
        check_eq("a_rdy1", 32'(req_ready_1), 32'd0);
        check_eq("a_busy_idle", 32'(busy), 32'd0);
        tick();
        req_valid_0 = 1'b0;
        check_eq("a_busy_exec", 32'(busy), 32'd1);
        check_eq("a_vld_exec", 32'(rsp_valid_0), 32'd0);
        check_eq("a_res_exec", rsp_result, 32'd0);
        tick();
        check_eq("a_vld0", 32'(rsp_valid_0), 32'd1);
        check_eq("a_vld1", 32'(rsp_valid_1), 32'd0);
        check_eq("a_res", rsp_result, 32'h0000000C);
        tick();
        check_eq("a_idle", 32'(busy), 32'd0);
        check_eq("a_vld_off", 32'(rsp_valid_0), 32'd0);

        // Continuous contention: last grant was 0, so requester 1 goes first
        req_ctrl_0 = ALU_SUB; req_in1_0 = 32'd10;         req_in2_0 = 32'd3;
        req_ctrl_1 = ALU_SLT; req_in1_1 = 32'hFFFFFFFF;   req_in2_1 = 32'd1;
        req_valid_0 = 1'b1; req_valid_1 = 1'b1;
        rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
        exp_g = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("b_rdy0", 32'(req_ready_0), 32'(!exp_g));
            check_eq("b_rdy1", 32'(req_ready_1), 32'(exp_g));
            tick();
            tick();
            check_eq("b_vld0", 32'(rsp_valid_0), 32'(!exp_g));
            check_eq("b_vld1", 32'(rsp_valid_1), 32'(exp_g));
            check_eq("b_res", rsp_result, exp_g ? 32'h00000001 : 32'h00000007);
            tick();
            exp_g = ~exp_g;
        end
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
        tick();

        // Backpressure on requester 0 with requester 1 waiting
        req_ctrl_0 = ALU_ADD; req_in1_0 = 32'h100; req_in2_0 = 32'h23;
        req_valid_0 = 1'b1; rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b1;
        #1;
        check_eq("c_rdy0", 32'(req_ready_0), 32'd1);
        tick();
        req_valid_0 = 1'b0;
        req_ctrl_1 = ALU_XOR; req_in1_1 = 32'h0000F0F0; req_in2_1 = 32'h00000FF0;
        req_valid_1 = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            check_eq("c_hold_vld0", 32'(rsp_valid_0), 32'd1);
            check_eq("c_hold_res",  rsp_result, 32'h00000123);
            check_eq("c_hold_busy", 32'(busy), 32'd1);
            check_eq("c_hold_rdy1", 32'(req_ready_1), 32'd0);
            check_eq("c_hold_vld1", 32'(rsp_valid_1), 32'd0);
            tick();
        end
        rsp_ready_0 = 1'b1;
        #1;
        check_eq("c_hs_vld0", 32'(rsp_valid_0), 32'd1);
        tick();
        check_eq("c_rdy1", 32'(req_ready_1), 32'd1);
        tick();
        req_valid_1 = 1'b0;
        tick();
        check_eq("c_vld1", 32'(rsp_valid_1), 32'd1);
        check_eq("c_res1", rsp_result, 32'h0000FF00);
        tick();

        // Shifts, compares and an unrecognised encoding
        do_op("sra",  1'b0, ALU_SRA,  32'h80000000, 32'd4,        32'hF8000000);
        do_op("sll",  1'b1, ALU_SLL,  32'h00000001, 32'd33,       32'h00000002);
        do_op("srl",  1'b0, ALU_SRL,  32'h80000000, 32'd31,       32'h00000001);
        do_op("bltu", 1'b1, ALU_BLTU, 32'd1,        32'hFFFFFFFF, 32'h00000001);
        do_op("bge",  1'b0, ALU_BGE,  32'hFFFFFFFF, 32'd1,        32'h00000000);
        do_op("unk",  1'b1, alu_control_t'(5'd31), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);

        // Reset during EXEC of requester 1
        req_ctrl_1 = ALU_ADD; req_in1_1 = 32'd1; req_in2_1 = 32'd2;
        req_valid_1 = 1'b1; rsp_ready_1 = 1'b0;
        #1;
        check_eq("e_rdy1", 32'(req_ready_1), 32'd1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("e_rst_busy", 32'(busy), 32'd0);
        check_eq("e_rst_vld0", 32'(rsp_valid_0), 32'd0);
        check_eq("e_rst_vld1", 32'(rsp_valid_1), 32'd0);
        check_eq("e_rst_res",  rsp_result, 32'd0);
        check_eq("e_rst_rdy1", 32'(req_ready_1), 32'd0);
        req_valid_1 = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("e_no_vld1", 32'(rsp_valid_1), 32'd0);
            check_eq("e_no_busy", 32'(busy), 32'd0);
        end
        req_ctrl_0 = ALU_ADD; req_in1_0 = 32'd2; req_in2_0 = 32'd3;
        req_valid_0 = 1'b1; req_valid_1 = 1'b1;
        rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
        #1;
        check_eq("e_cont_rdy0", 32'(req_ready_0), 32'd1);
        check_eq("e_cont_rdy1", 32'(req_ready_1), 32'd0);
        tick();
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
        tick();
        check_eq("e_vld0", 32'(rsp_valid_0), 32'd1);
        check_eq("e_res",  rsp_result, 32'd5);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
